// File: rtl/qpi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qpi_psram_responder
// Brief    : Behavioural PSRAM device model answering SPI/QPI mode switches
//            and QPI read (EB) / write (38) bursts from a small byte array.
// Revision : 1.0 - initial release
// ============================================================================
module qpi_psram_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int WAITCYCLES = 6
) (
  input  logic       i_clkRAM,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic [3:0] i_psram_data,
  output logic [3:0] o_psram_data,
  output logic       o_psram_oe,
  output logic       o_qpi_mode,
  output logic       o_cmd_err
);

  localparam logic [3:0] SPI_IDLE  = 4'd0;
  localparam logic [3:0] SPI_CMD   = 4'd1;
  localparam logic [3:0] QPI_IDLE  = 4'd2;
  localparam logic [3:0] QPI_CMD   = 4'd3;
  localparam logic [3:0] QPI_ADDR  = 4'd4;
  localparam logic [3:0] QPI_WAIT  = 4'd5;
  localparam logic [3:0] QPI_RDATA = 4'd6;
  localparam logic [3:0] QPI_WDATA = 4'd7;
  localparam logic [3:0] IGNORE    = 4'd8;

  // Last dummy cycle; the data phase starts on the cycle after it.
  localparam logic [5:0] c_WAIT_END = 6'(7 + WAITCYCLES);

  logic [3:0]           r_state;
  logic [5:0]           r_n;
  logic [7:0]           r_cmd;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_rbyte;
  logic [3:0]           r_whi;
  logic                 r_nib;
  logic                 r_oe;
  logic [3:0]           r_dout;
  logic                 r_qpi;
  logic                 r_err;
  logic [7:0]           r_mem [2**ADDR_BITS];

  logic [7:0] w_cmd_spi;
  logic [7:0] w_cmd_qpi;

  assign w_cmd_spi = {r_cmd[6:0], i_psram_data[0]};
  assign w_cmd_qpi = {r_cmd[3:0], i_psram_data};

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      r_state <= SPI_IDLE;
      r_n     <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_rbyte <= '0;
      r_whi   <= '0;
      r_nib   <= 1'b0;
      r_oe    <= 1'b0;
      r_dout  <= '0;
      r_qpi   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_psram_cs) begin
        r_state <= r_qpi ? QPI_IDLE : SPI_IDLE;
        r_n     <= '0;
        r_nib   <= 1'b0;
        r_oe    <= 1'b0;
        r_dout  <= '0;
      end else begin
        if (r_n != '1) r_n <= r_n + 6'd1;
        case (r_state)
          SPI_IDLE: begin
            r_cmd   <= {7'b0, i_psram_data[0]};
            r_state <= SPI_CMD;
          end
          SPI_CMD: begin
            r_cmd <= w_cmd_spi;
            if (r_n == 6'd7) begin
              if (w_cmd_spi == 8'h35) r_qpi <= 1'b1;
              else                    r_err <= 1'b1;
              r_state <= IGNORE;
            end
          end
          QPI_IDLE: begin
            r_cmd   <= {4'h0, i_psram_data};
            r_state <= QPI_CMD;
          end
          QPI_CMD: begin
            r_cmd <= w_cmd_qpi;
            if (w_cmd_qpi == 8'hEB || w_cmd_qpi == 8'h38) begin
              r_state <= QPI_ADDR;
            end else if (w_cmd_qpi == 8'hF5) begin
              r_qpi   <= 1'b0;
              r_state <= IGNORE;
            end else begin
              r_err   <= 1'b1;
              r_state <= IGNORE;
            end
          end
          QPI_ADDR: begin
            // Six nibbles always refill the index; upper address bits fall off.
            r_addr <= ADDR_BITS'({r_addr, i_psram_data});
            r_nib  <= 1'b0;
            if (r_n == 6'd7) r_state <= (r_cmd == 8'hEB) ? QPI_WAIT : QPI_WDATA;
          end
          QPI_WAIT: begin
            r_rbyte <= r_mem[r_addr];
            if (r_n == c_WAIT_END) r_state <= QPI_RDATA;
          end
          QPI_RDATA: begin
            r_oe <= 1'b1;
            if (!r_nib) begin
              r_dout <= r_rbyte[7:4];
              r_nib  <= 1'b1;
            end else begin
              // Fetch the next byte now so the burst continues without a gap.
              r_dout  <= r_rbyte[3:0];
              r_nib   <= 1'b0;
              r_addr  <= r_addr + 1'b1;
              r_rbyte <= r_mem[r_addr + 1'b1];
            end
          end
          QPI_WDATA: begin
            if (!r_nib) begin
              r_whi <= i_psram_data;
              r_nib <= 1'b1;
            end else begin
              r_mem[r_addr] <= {r_whi, i_psram_data};
              r_addr        <= r_addr + 1'b1;
              r_nib         <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_psram_oe   = r_oe;
  assign o_psram_data = r_oe ? r_dout : 4'h0;
  assign o_qpi_mode   = r_qpi;
  assign o_cmd_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qpi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpi_psram_responder
// Brief    : Self-checking bench for qpi_psram_responder with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpi_psram_responder;

  localparam int ADDR_BITS  = 10;
  localparam int WAITCYCLES = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [3:0] din;
  logic [3:0] dout;
  logic       oe;
  logic       qpi;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [2**ADDR_BITS];
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  qpi_psram_responder #(
    .ADDR_BITS (ADDR_BITS),
    .WAITCYCLES(WAITCYCLES)
  ) dut (
    .i_clkRAM    (clk),
    .reset       (reset),
    .i_psram_cs  (cs),
    .i_psram_data(din),
    .o_psram_data(dout),
    .o_psram_oe  (oe),
    .o_qpi_mode  (qpi),
    .o_cmd_err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic c, input logic [3:0] d);
    @(negedge clk);
    cs  = c;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    cycle(1'b0, d);
    check("oe_quiet", {31'b0, oe}, 32'd0);
  endtask

  task automatic end_cs();
    cycle(1'b1, 4'h0);
    check("oe_cs_high", {31'b0, oe}, 32'd0);
    check("data_cs_high", {28'b0, dout}, 32'd0);
    cycle(1'b1, 4'h0);
  endtask

  task automatic spi_cmd(input logic [7:0] c, input logic exp_qpi);
    logic [7:0] cc;
    cc = c;
    for (int i = 0; i < 8; i++) send({3'b0, cc[7-i]});
    check("spi_err", {31'b0, err}, {31'b0, (cc != 8'h35)});
    end_cs();
    check("spi_qpi_mode", {31'b0, qpi}, {31'b0, exp_qpi});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 0; i < 6; i++) send(a[23-4*i -: 4]);
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [15:0] bytes, input int nbytes,
                           input bit half);
    logic [7:0]           b;
    logic [ADDR_BITS-1:0] idx;
    send(4'h3);
    send(4'h8);
    send_addr(a);
    for (int k = 0; k < nbytes; k++) begin
      b   = (k == 0) ? bytes[15:8] : bytes[7:0];
      idx = a[ADDR_BITS-1:0] + ADDR_BITS'(k);
      send(b[7:4]);
      send(b[3:0]);
      model[idx] = b;
    end
    if (half) send(4'hF);
    end_cs();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int nbytes);
    logic [ADDR_BITS-1:0] idx;
    logic [3:0]           e;
    for (int k = 0; k < nbytes; k++) begin
      idx = a[ADDR_BITS-1:0] + ADDR_BITS'(k);
      exp_q.push_back(model[idx][7:4]);
      exp_q.push_back(model[idx][3:0]);
    end
    send(4'hE);
    send(4'hB);
    send_addr(a);
    for (int k = 0; k < WAITCYCLES; k++) send(4'h0);
    for (int k = 0; k < 2 * nbytes; k++) begin
      cycle(1'b0, 4'h0);
      check("rd_oe", {31'b0, oe}, 32'd1);
      e = exp_q.pop_front();
      check("rd_data", {28'b0, dout}, {28'b0, e});
    end
    end_cs();
    check("rd_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cs    = 1'b1;
    din   = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oe", {31'b0, oe}, 32'd0);
    check("rst_qpi", {31'b0, qpi}, 32'd0);
    check("rst_data", {28'b0, dout}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Enter QPI, then single-byte write/read round trip.
    spi_cmd(8'h35, 1'b1);
    qpi_write(24'h000010, 16'hA500, 1, 1'b0);
    qpi_read(24'h000010, 1);

    // Burst across the top of the array wraps to index 0.
    qpi_write(24'h0003FF, 16'h1122, 2, 1'b0);
    qpi_read(24'h0003FF, 2);
    qpi_read(24'h000000, 1);
    qpi_read(24'hFFF010, 1);

    // A lone nibble must not disturb the stored byte.
    qpi_write(24'h000020, 16'h5C00, 1, 1'b0);
    qpi_write(24'h000020, 16'h0000, 0, 1'b1);
    qpi_read(24'h000020, 1);

    // Reset in the middle of a read's dummy phase (n=10).
    send(4'hE);
    send(4'hB);
    send_addr(24'h000010);
    send(4'h0);
    send(4'h0);
    @(negedge clk);
    reset = 1'b1;
    cs    = 1'b0;
    din   = 4'h0;
    @(posedge clk);
    #1;
    check("midrst_oe", {31'b0, oe}, 32'd0);
    check("midrst_qpi", {31'b0, qpi}, 32'd0);
    check("midrst_data", {28'b0, dout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 4'h0);
    spi_cmd(8'h35, 1'b1);
    qpi_read(24'h000010, 1);

    // Unsupported QPI command, then exit QPI.
    send(4'h9);
    cycle(1'b0, 4'hF);
    check("qpi_err_pulse", {31'b0, err}, 32'd1);
    send(4'h0);
    check("qpi_err_clear", {31'b0, err}, 32'd0);
    for (int k = 0; k < 4; k++) send(4'hF);
    end_cs();
    check("qpi_err_mode_kept", {31'b0, qpi}, 32'd1);
    send(4'hF);
    send(4'h5);
    check("f5_mode_clear", {31'b0, qpi}, 32'd0);
    end_cs();

    // Bad SPI command keeps SPI mode.
    spi_cmd(8'h12, 1'b0);
    check("spi_err_clear", {31'b0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
